vpu_forward_stim_driver: RTL

- Synthesizable stimulus generator and reference model for the 8-lane vector forwarding unit; drives the opposite end of the forwarding interface that the forwarding monitor observes.
- Emits pseudo-random EX/MEM/WB producer stages, VRF read data and a consumer src_tag each cycle.
- Emits a same-cycle expected out_data/out_ready_mask for scoreboard compare.
- Sits in the bench or on an FPGA self-test wrapper, ahead of the forwarding unit.

---
 rtl/vpu_fwd_pkg.sv | 36 +++
 rtl/vpu_fwd_ref_model.sv | 58 +++++
 rtl/vpu_forward_stim_driver.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vpu_fwd_pkg.sv
// ---------------------------------------------------------------------------
// vpu_fwd_pkg
// Shared definitions for the 8-lane vector forwarding stimulus driver and its
// combinational reference model: default geometry, stage encodings, LFSR
// constants, the driver FSM state type and the LFSR step function.
// No ports (package).
// ---------------------------------------------------------------------------
package vpu_fwd_pkg;

    localparam int LANES_DEF = 8;
    localparam int EW_DEF    = 64;
    localparam int VREG_DEF  = 5;
    localparam int VER_DEF   = 4;
    localparam int TAGW_DEF  = VREG_DEF + VER_DEF;

    // Producer stage encodings, also used as the src_tag select code.
    localparam logic [1:0] STG_EX  = 2'd0;
    localparam logic [1:0] STG_MEM = 2'd1;
    localparam logic [1:0] STG_WB  = 2'd2;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stim_state_t;

    // Galois LFSR, right shift; taps applied when the shifted-out bit is 1.
    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
    endfunction

endpackage

// File: rtl/vpu_fwd_ref_model.sv
// ---------------------------------------------------------------------------
// vpu_fwd_ref_model
// Combinational priority-select reference for the vector forwarding unit.
// Per lane: EX hit, else MEM hit, else WB hit, else VRF-ready data, else 0.
// A stage hits when its lane valid is set and its tag equals src_tag over the
// full tag width (register index and rename version).
// Ports:
//   ex/mem/wb_tag          in  TAGW          stage producer tags
//   ex/mem/wb_valid_mask   in  LANES         stage lane valids
//   ex/mem/wb_data         in  LANES*EW      stage lane data
//   vrf_ready_mask         in  LANES         VRF lane readiness
//   vrf_data               in  LANES*EW      VRF lane data
//   src_tag                in  TAGW          consumer tag
//   exp_data               out LANES*EW      selected data per lane
//   exp_ready_mask         out LANES         lane had any source
// ---------------------------------------------------------------------------
module vpu_fwd_ref_model #(
    parameter int LANES = 8,
    parameter int EW    = 64,
    parameter int TAGW  = 9
) (
    input  logic [TAGW-1:0]     ex_tag,
    input  logic [TAGW-1:0]     mem_tag,
    input  logic [TAGW-1:0]     wb_tag,
    input  logic [LANES-1:0]    ex_valid_mask,
    input  logic [LANES-1:0]    mem_valid_mask,
    input  logic [LANES-1:0]    wb_valid_mask,
    input  logic [LANES*EW-1:0] ex_data,
    input  logic [LANES*EW-1:0] mem_data,
    input  logic [LANES*EW-1:0] wb_data,
    input  logic [LANES-1:0]    vrf_ready_mask,
    input  logic [LANES*EW-1:0] vrf_data,
    input  logic [TAGW-1:0]     src_tag,
    output logic [LANES*EW-1:0] exp_data,
    output logic [LANES-1:0]    exp_ready_mask
);

    always_comb begin
        exp_data       = '0;
        exp_ready_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (ex_valid_mask[i] && (ex_tag == src_tag)) begin
                exp_data[i*EW +: EW] = ex_data[i*EW +: EW];
                exp_ready_mask[i]    = 1'b1;
            end else if (mem_valid_mask[i] && (mem_tag == src_tag)) begin
                exp_data[i*EW +: EW] = mem_data[i*EW +: EW];
                exp_ready_mask[i]    = 1'b1;
            end else if (wb_valid_mask[i] && (wb_tag == src_tag)) begin
                exp_data[i*EW +: EW] = wb_data[i*EW +: EW];
                exp_ready_mask[i]    = 1'b1;
            end else if (vrf_ready_mask[i]) begin
                exp_data[i*EW +: EW] = vrf_data[i*EW +: EW];
                exp_ready_mask[i]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vpu_forward_stim_driver.sv
// ---------------------------------------------------------------------------
// vpu_forward_stim_driver
// Pseudo-random stimulus generator for the 8-lane vector forwarding unit plus
// a same-cycle expected result. A run injects cfg_count EX producers from a
// 16-bit LFSR, then drains the EX/MEM/WB pipe for 3 cycles with no valids.
//
// Optional build macro: VPU_STIM_VERSION_ALIAS_EN. When defined and LFSR bit
// 2 is set with a stage select (0..2), src_tag takes that stage's register
// index with version+1, so the stage is a stale alias and must not forward.
//
// Interface handshake: there is no back-pressure. start is only sampled in
// IDLE; stim_valid qualifies every stimulus/expected output in the same
// cycle; done is a one-cycle pulse from the DONE state.
//
// Ports:
//   clk, rst_n              in   clock, async active-low reset
//   start                   in   begin a run (IDLE only)
//   cfg_seed                in   16  LFSR seed (0 -> 16'hACE1)
//   cfg_count               in   16  injection cycles
//   busy, done, stim_valid  out  run status
//   ex/mem/wb_tag           out  TAGW stage tags
//   ex/mem/wb_valid_mask    out  LANES stage lane valids
//   ex/mem/wb_data          out  LANES*EW stage lane data
//   vrf_ready_mask          out  LANES, vrf_data out LANES*EW
//   src_tag                 out  TAGW consumer tag
//   exp_data                out  LANES*EW expected forwarded data
//   exp_ready_mask          out  LANES expected ready mask
//   fsm_state               out  current FSM state (debug)
// ---------------------------------------------------------------------------
module vpu_forward_stim_driver
    import vpu_fwd_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int EW    = EW_DEF,
    parameter int VREG  = VREG_DEF,
    parameter int VER   = VER_DEF,
    parameter int TAGW  = VREG + VER
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         cfg_seed,
    input  logic [15:0]         cfg_count,
    output logic                busy,
    output logic                done,
    output logic                stim_valid,
    output logic [TAGW-1:0]     ex_tag,
    output logic [TAGW-1:0]     mem_tag,
    output logic [TAGW-1:0]     wb_tag,
    output logic [LANES-1:0]    ex_valid_mask,
    output logic [LANES-1:0]    mem_valid_mask,
    output logic [LANES-1:0]    wb_valid_mask,
    output logic [LANES*EW-1:0] ex_data,
    output logic [LANES*EW-1:0] mem_data,
    output logic [LANES*EW-1:0] wb_data,
    output logic [LANES-1:0]    vrf_ready_mask,
    output logic [LANES*EW-1:0] vrf_data,
    output logic [TAGW-1:0]     src_tag,
    output logic [LANES*EW-1:0] exp_data,
    output logic [LANES-1:0]    exp_ready_mask,
    output stim_state_t         fsm_state
);

    stim_state_t state_q, state_d;

    logic [15:0]         remain_q;
    logic [1:0]          drain_q;
    logic [15:0]         lfsr_q;
    logic [15:0]         cyc_q;
    logic                step;
    logic                inject;
    logic [TAGW-1:0]     ex_tag_new;
    logic [TAGW-1:0]     src_tag_new;
    logic [LANES*EW-1:0] ex_data_new;
    logic [LANES*EW-1:0] vrf_data_new;

    // Lane word: zero-extended {cycle count, lane index, tag}.
    function automatic logic [EW-1:0] lane_word(input logic [15:0] c,
                                                input logic [7:0] lane,
                                                input logic [TAGW-1:0] tag);
        logic [EW-1:0] w;
        w = '0;
        w[TAGW+23:0] = {c, lane, tag};
        return w;
    endfunction

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (cfg_count != 16'd0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (remain_q == 16'd1) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q == 2'd2) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    assign step      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign inject    = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign fsm_state = state_q;

    // ---------------- run control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= 16'd0;
            drain_q  <= 2'd0;
            lfsr_q   <= LFSR_SEED;
            cyc_q    <= 16'd0;
        end else begin
            cyc_q <= cyc_q + 16'd1;
            if ((state_q == ST_IDLE) && start) begin
                lfsr_q   <= (cfg_seed == 16'd0) ? LFSR_SEED : cfg_seed;
                remain_q <= cfg_count;
                drain_q  <= 2'd0;
            end else if (step) begin
                lfsr_q <= lfsr_next(lfsr_q);
                if (inject) remain_q <= remain_q - 16'd1;
                else        drain_q  <= drain_q + 2'd1;
            end
        end
    end

    // ---------------- next-stage values ----------------
    // src select looks at the stage tags as they will be after this edge's
    // shift: MEM gets the current EX tag, WB gets the current MEM tag.
    always_comb begin
        ex_tag_new = lfsr_q[TAGW-1:0];
        case (lfsr_q[1:0])
            STG_EX:  src_tag_new = ex_tag_new;
            STG_MEM: src_tag_new = ex_tag;
            STG_WB:  src_tag_new = mem_tag;
            default: src_tag_new = lfsr_q[15 -: TAGW];
        endcase
`ifdef VPU_STIM_VERSION_ALIAS_EN
        if (lfsr_q[2] && (lfsr_q[1:0] != 2'd3)) begin
            src_tag_new[VER-1:0] = src_tag_new[VER-1:0] + {{(VER-1){1'b0}}, 1'b1};
        end
`endif
    end

    always_comb begin
        ex_data_new  = '0;
        vrf_data_new = '0;
        for (int i = 0; i < LANES; i++) begin
            ex_data_new[i*EW +: EW]  = lane_word(cyc_q, 8'(i), ex_tag_new);
            vrf_data_new[i*EW +: EW] = lane_word(cyc_q, 8'(i), src_tag_new);
        end
    end

    // ---------------- stage pipe ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_valid     <= 1'b0;
            ex_tag         <= '0;
            mem_tag        <= '0;
            wb_tag         <= '0;
            ex_valid_mask  <= '0;
            mem_valid_mask <= '0;
            wb_valid_mask  <= '0;
            ex_data        <= '0;
            mem_data       <= '0;
            wb_data        <= '0;
            vrf_ready_mask <= '0;
            vrf_data       <= '0;
            src_tag        <= '0;
        end else begin
            stim_valid <= step;
            if (step) begin
                wb_tag         <= mem_tag;
                wb_valid_mask  <= mem_valid_mask;
                wb_data        <= mem_data;
                mem_tag        <= ex_tag;
                mem_valid_mask <= ex_valid_mask;
                mem_data       <= ex_data;
                ex_tag         <= ex_tag_new;
                ex_data        <= ex_data_new;
                // DRAIN keeps shifting but injects no valid lanes.
                ex_valid_mask  <= inject ? lfsr_q[8 +: LANES] : '0;
                vrf_ready_mask <= inject ? lfsr_q[0 +: LANES] : '0;
                vrf_data       <= vrf_data_new;
                src_tag        <= src_tag_new;
            end
        end
    end

    // ---------------- expected result ----------------
    vpu_fwd_ref_model #(
        .LANES(LANES),
        .EW   (EW),
        .TAGW (TAGW)
    ) u_ref (
        .ex_tag        (ex_tag),
        .mem_tag       (mem_tag),
        .wb_tag        (wb_tag),
        .ex_valid_mask (ex_valid_mask),
        .mem_valid_mask(mem_valid_mask),
        .wb_valid_mask (wb_valid_mask),
        .ex_data       (ex_data),
        .mem_data      (mem_data),
        .wb_data       (wb_data),
        .vrf_ready_mask(vrf_ready_mask),
        .vrf_data      (vrf_data),
        .src_tag       (src_tag),
        .exp_data      (exp_data),
        .exp_ready_mask(exp_ready_mask)
    );

endmodule
